// File: rtl/cp0_if.sv
// -----------------------------------------------------------------------------
// cp0_if : pipeline <-> coprocessor 0 signal bundle.
//
// The M stage (master) drives the mfc0/mtc0 register numbers and write data,
// the victim PC / branch-delay flag / exception code, the eret strobe and the
// hardware interrupt lines coming back from the bridge.  CP0 (slave) returns
// the interrupt request, the current EPC and the mfc0 read data.
//
//   A1      [4:0]  read register number (mfc0 rd)
//   A2      [4:0]  write register number (mtc0 rd)
//   DIn     [31:0] mtc0 write data
//   WE             mtc0 write enable
//   PC      [31:0] PC of the instruction in M
//   BD             that instruction is in a branch delay slot
//   ExcCode [4:0]  M-stage exception code, 0 = none
//   HWInt   [5:0]  hardware interrupt lines [7:2]
//   EXLClr         eret in M
//   IntReq         divert to the handler this cycle
//   EPC     [31:0] current EPC register
//   DOut    [31:0] read data for A1
// -----------------------------------------------------------------------------
interface cp0_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCode;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        IntReq;
    logic [31:0] EPC;
    logic [31:0] DOut;

    modport master (
        output A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
        input  IntReq, EPC, DOut
    );

    modport slave (
        input  A1, A2, DIn, WE, PC, BD, ExcCode, HWInt, EXLClr,
        output IntReq, EPC, DOut
    );
endinterface

// File: rtl/cp0.sv
// -----------------------------------------------------------------------------
// cp0 : system coprocessor 0 for the pipelined MIPS core.
//
// Holds SR (12), Cause (13), EPC (14) and PRId (15).  Samples the six hardware
// interrupt lines into Cause.IP every cycle, combines them with the live
// M-stage exception code and raises IntReq when the pipeline must be diverted
// to the handler.  On the edge that ends an IntReq cycle it records EXL, the
// cause code, the delay-slot flag and the restart PC.  eret (EXLClr) clears
// EXL so that the handler can return through EPC.
//
// Ports:
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high; also forces IntReq low in its own cycle
//   bus    cp0_if.slave bundle (see cp0_if.sv for the individual signals)
//
// IntReq and DOut are combinational: IntReq must react to ExcCode in the same
// cycle and mfc0 reads the register file directly in M.
// -----------------------------------------------------------------------------
module cp0 #(
    parameter logic [31:0] PRID_VAL = 32'h0000_0007
) (
    input  logic  clk,
    input  logic  reset,
    cp0_if.slave  bus
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // Restart address for the victim: a delay-slot instruction restarts at
    // its branch (PC-4, modulo 2^32).  EPC is always word aligned.
    function automatic logic [31:0] victim_epc(input logic [31:0] pc,
                                               input logic        bd);
        logic [31:0] restart;
        if (bd) begin
            restart = pc - 32'd4;
        end else begin
            restart = pc;
        end
        return {restart[31:2], 2'b00};
    endfunction

    // ---------------------------------------------------------------- state
    logic [5:0]  im_r;          // SR.IM[15:10]
    logic        exl_r;         // SR.EXL
    logic        ie_r;          // SR.IE
    logic [5:0]  ip_r;          // Cause.IP[15:10], read-only copy of HWInt
    logic        bd_r;          // Cause.BD
    logic [4:0]  exc_code_r;    // Cause.ExcCode
    logic [31:0] epc_r;

    logic [5:0]  im_nxt_s;
    logic        exl_nxt_s;
    logic        ie_nxt_s;
    logic [5:0]  ip_nxt_s;
    logic        bd_nxt_s;
    logic [4:0]  exc_code_nxt_s;
    logic [31:0] epc_nxt_s;

    logic        int_p_s;
    logic        exc_p_s;
    logic        int_req_s;
    logic [4:0]  rec_code_s;
    logic        sr_we_s;
    logic        epc_we_s;
    logic [31:0] sr_word_s;
    logic [31:0] cause_word_s;
    logic [31:0] dout_s;

    // Pending-event evaluation and interrupt-over-exception priority.
    always_comb begin
        int_p_s   = ie_r & ~exl_r & (|(ip_r & im_r));
        exc_p_s   = ~exl_r & (bus.ExcCode != 5'd0);
        int_req_s = ~reset & (int_p_s | exc_p_s);
        if (int_p_s) begin
            rec_code_s = 5'd0;
        end else begin
            rec_code_s = bus.ExcCode;
        end
    end

    // mtc0 decode; a write that coincides with IntReq is dropped.
    always_comb begin
        sr_we_s  = bus.WE & ~int_req_s & (bus.A2 == REG_SR);
        epc_we_s = bus.WE & ~int_req_s & (bus.A2 == REG_EPC);
    end

    // Next-state for every CP0 field.
    always_comb begin
        im_nxt_s       = im_r;
        exl_nxt_s      = exl_r;
        ie_nxt_s       = ie_r;
        bd_nxt_s       = bd_r;
        exc_code_nxt_s = exc_code_r;
        epc_nxt_s      = epc_r;
        // IP tracks the lines every cycle regardless of anything else.
        ip_nxt_s       = bus.HWInt;

        if (int_req_s) begin
            exl_nxt_s      = 1'b1;
            exc_code_nxt_s = rec_code_s;
            bd_nxt_s       = bus.BD;
            epc_nxt_s      = victim_epc(bus.PC, bus.BD);
        end else begin
            if (sr_we_s) begin
                im_nxt_s  = bus.DIn[15:10];
                exl_nxt_s = bus.DIn[1];
                ie_nxt_s  = bus.DIn[0];
            end else begin
                im_nxt_s  = im_r;
            end

            if (epc_we_s) begin
                epc_nxt_s = {bus.DIn[31:2], 2'b00};
            end else begin
                epc_nxt_s = epc_r;
            end

            // eret is applied after any same-cycle SR write, so it wins on
            // EXL while IM/IE still take the written value.
            if (bus.EXLClr) begin
                exl_nxt_s = 1'b0;
            end else begin
                exl_nxt_s = exl_nxt_s;
            end
        end
    end

    // CP0 register file; reset clears everything including a live EXL.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            ip_r       <= 6'd0;
            bd_r       <= 1'b0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            im_r       <= im_nxt_s;
            exl_r      <= exl_nxt_s;
            ie_r       <= ie_nxt_s;
            ip_r       <= ip_nxt_s;
            bd_r       <= bd_nxt_s;
            exc_code_r <= exc_code_nxt_s;
            epc_r      <= epc_nxt_s;
        end
    end

    // Architectural views of SR and Cause; unimplemented bits read 0.
    always_comb begin
        sr_word_s    = {16'd0, im_r, 8'd0, exl_r, ie_r};
        cause_word_s = {bd_r, 15'd0, ip_r, 3'd0, exc_code_r, 2'd0};
    end

    // mfc0 read mux; registers are read as stored, no write-through.
    always_comb begin
        case (bus.A1)
            REG_SR:    dout_s = sr_word_s;
            REG_CAUSE: dout_s = cause_word_s;
            REG_EPC:   dout_s = epc_r;
            REG_PRID:  dout_s = PRID_VAL;
            default:   dout_s = 32'd0;
        endcase
    end

    assign bus.IntReq = int_req_s;
    assign bus.EPC    = epc_r;
    assign bus.DOut   = dout_s;

endmodule

// File: tb/tb_cp0.sv
// -----------------------------------------------------------------------------
// tb_cp0 : self-checking bench for cp0.
// A small architectural model (whole SR/Cause/EPC words updated by the
// documented rules) predicts IntReq, EPC and every mfc0 read.  Directed
// scenarios also compare against literal values, then a randomized run
// exercises mixed traffic against the model.
// -----------------------------------------------------------------------------
module tb_cp0;

    logic clk;
    logic reset;
    cp0_if bus();

    cp0 #(.PRID_VAL(32'h0000_0007)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // ---------------------------------------------------------------- model
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    function automatic logic m_int_p();
        return m_sr[0] && !m_sr[1] && ((m_cause[15:10] & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_req();
        return !reset && (m_int_p() || (!m_sr[1] && bus.ExcCode != 5'd0));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_0007;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock edge and update the model from the sampled inputs.
    task automatic tick();
        logic        req;
        logic [4:0]  code;
        logic [31:0] restart;
        @(posedge clk);
        req = m_req();
        if (reset) begin
            m_sr    = 32'd0;
            m_cause = 32'd0;
            m_epc   = 32'd0;
        end else if (req) begin
            code    = m_int_p() ? 5'd0 : bus.ExcCode;
            restart = bus.BD ? bus.PC - 32'd4 : bus.PC;
            m_epc   = restart & 32'hFFFF_FFFC;
            m_sr[1] = 1'b1;
            m_cause = ({31'd0, bus.BD} << 31) | ({26'd0, bus.HWInt} << 10)
                    | ({27'd0, code} << 2);
        end else begin
            if (bus.WE && bus.A2 == 5'd12) m_sr = bus.DIn & 32'h0000_FC03;
            if (bus.WE && bus.A2 == 5'd14) m_epc = bus.DIn & 32'hFFFF_FFFC;
            if (bus.EXLClr) m_sr[1] = 1'b0;
            m_cause[15:10] = bus.HWInt;
        end
        #2;
    endtask

    task automatic idle_inputs();
        bus.A1 = 5'd0; bus.A2 = 5'd0; bus.DIn = 32'd0; bus.WE = 1'b0;
        bus.PC = 32'd0; bus.BD = 1'b0; bus.ExcCode = 5'd0; bus.HWInt = 6'd0;
        bus.EXLClr = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        logic [31:0] lit [4];
        lit[0] = 32'd0; lit[1] = 32'd0; lit[2] = 32'd0; lit[3] = 32'h0000_0007;
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus.IntReq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_intreq: got %0b want 0", bus.IntReq);
            end
            tick();
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.A1 = 5'(12 + i);
            #1;
            n_checks++;
            if (bus.DOut !== lit[i] || bus.DOut !== m_read(bus.A1)) begin
                n_fail++;
                $display("FAIL reset_read r%0d: got %h want %h", bus.A1, bus.DOut, lit[i]);
            end
            n_checks++;
            if (bus.IntReq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle_intreq: got %0b want 0", bus.IntReq);
            end
        end
    endtask

    task automatic test_mtc0();
        logic [31:0] cause_before;
        idle_inputs();
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'hFFFF_FFFF; bus.A1 = 5'd12;
        #1;
        n_checks++;
        if (bus.DOut !== 32'd0) begin
            n_fail++;
            $display("FAIL mtc0_no_writethrough: got %h want 00000000", bus.DOut);
        end
        tick();
        bus.WE = 1'b0;
        #1;
        n_checks++;
        if (bus.DOut !== 32'h0000_FC03 || bus.DOut !== m_read(5'd12)) begin
            n_fail++;
            $display("FAIL mtc0_sr: got %h want 0000fc03", bus.DOut);
        end
        bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3003;
        tick();
        bus.WE = 1'b0; bus.A1 = 5'd14;
        #1;
        n_checks++;
        if (bus.DOut !== 32'h0000_3000 || bus.EPC !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL mtc0_epc: got %h/%h want 00003000", bus.DOut, bus.EPC);
        end
        bus.A1 = 5'd13;
        #1;
        cause_before = m_read(5'd13);
        bus.WE = 1'b1; bus.A2 = 5'd13; bus.DIn = 32'hFFFF_FFFF;
        tick();
        bus.WE = 1'b0;
        #1;
        n_checks++;
        if (bus.DOut !== cause_before) begin
            n_fail++;
            $display("FAIL mtc0_cause_ro: got %h want %h", bus.DOut, cause_before);
        end
        // Clear SR again (EXL was set by the all-ones write).
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'd0;
        tick();
        bus.WE = 1'b0;
    endtask

    task automatic test_interrupt();
        idle_inputs();
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        tick();
        bus.WE = 1'b0; bus.PC = 32'h0000_3010; bus.BD = 1'b0;
        bus.HWInt = 6'b000001;
        #1;
        n_checks++;
        if (bus.IntReq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_before_sample: got %0b want 0", bus.IntReq);
        end
        tick();
        #1;
        n_checks++;
        if (bus.IntReq !== 1'b1 || m_req() !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_raise: got %0b want 1", bus.IntReq);
        end
        tick();
        bus.A1 = 5'd13;
        #1;
        n_checks++;
        if (bus.EPC !== 32'h0000_3010 || bus.DOut !== 32'h0000_0400 || bus.IntReq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_capture: epc %h cause %h intreq %0b want 00003010 00000400 0",
                     bus.EPC, bus.DOut, bus.IntReq);
        end
        bus.A1 = 5'd12;
        #1;
        n_checks++;
        if (bus.DOut !== 32'h0000_0403) begin
            n_fail++;
            $display("FAIL irq_exl: got %h want 00000403", bus.DOut);
        end
        bus.HWInt = 6'd0;
        tick();
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
        #1;
        n_checks++;
        if (bus.DOut !== 32'h0000_0401 || bus.IntReq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_eret: sr %h intreq %0b want 00000401 0", bus.DOut, bus.IntReq);
        end
    endtask

    task automatic test_delay_slot_exc();
        idle_inputs();
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'd0;
        tick();
        bus.ExcCode = 5'd10; bus.PC = 32'h0000_3024; bus.BD = 1'b1;
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0401;
        #1;
        n_checks++;
        if (bus.IntReq !== 1'b1) begin
            n_fail++;
            $display("FAIL exc_same_cycle: got %0b want 1", bus.IntReq);
        end
        tick();
        idle_inputs();
        bus.A1 = 5'd13;
        #1;
        n_checks++;
        if (bus.EPC !== 32'h0000_3020 || bus.DOut !== 32'h8000_0028) begin
            n_fail++;
            $display("FAIL exc_capture: epc %h cause %h want 00003020 80000028", bus.EPC, bus.DOut);
        end
        bus.A1 = 5'd12;
        #1;
        n_checks++;
        if (bus.DOut !== 32'h0000_0002 || bus.DOut !== m_read(5'd12)) begin
            n_fail++;
            $display("FAIL exc_mtc0_dropped: sr %h want 00000002", bus.DOut);
        end
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
    endtask

    task automatic test_masking_priority();
        idle_inputs();
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0403;
        tick();
        bus.WE = 1'b0; bus.ExcCode = 5'd4; bus.HWInt = 6'b000001;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (bus.IntReq !== 1'b0) begin
                n_fail++;
                $display("FAIL mask_exl: got %0b want 0", bus.IntReq);
            end
            tick();
        end
        bus.EXLClr = 1'b1;
        #1;
        n_checks++;
        if (bus.IntReq !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_eret_cycle: got %0b want 0", bus.IntReq);
        end
        tick();
        bus.EXLClr = 1'b0; bus.PC = 32'h0000_3040;
        #1;
        n_checks++;
        if (bus.IntReq !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_refire: got %0b want 1", bus.IntReq);
        end
        tick();
        bus.A1 = 5'd13;
        #1;
        n_checks++;
        if (bus.DOut[6:2] !== 5'd0 || bus.DOut !== m_read(5'd13) || bus.EPC !== 32'h0000_3040) begin
            n_fail++;
            $display("FAIL prio_code: cause %h epc %h want code 0 epc 00003040", bus.DOut, bus.EPC);
        end
        idle_inputs();
        tick();
        bus.EXLClr = 1'b1;
        tick();
        bus.EXLClr = 1'b0;
    endtask

    task automatic test_reset_mid_handler();
        idle_inputs();
        bus.ExcCode = 5'd8; bus.PC = 32'h0000_3100;
        tick();
        bus.ExcCode = 5'd0; bus.WE = 1'b1; bus.A2 = 5'd14; bus.DIn = 32'h0000_3000;
        tick();
        bus.WE = 1'b0; bus.A1 = 5'd12;
        #1;
        n_checks++;
        if (bus.DOut[1] !== 1'b1 || bus.EPC !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL midh_setup: sr %h epc %h want exl 1 epc 00003000", bus.DOut, bus.EPC);
        end
        reset = 1'b1; bus.ExcCode = 5'd12;
        bus.WE = 1'b1; bus.A2 = 5'd12; bus.DIn = 32'h0000_0001;
        #1;
        n_checks++;
        if (bus.IntReq !== 1'b0) begin
            n_fail++;
            $display("FAIL midh_reset_intreq: got %0b want 0", bus.IntReq);
        end
        tick();
        reset = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            bus.A1 = 5'(12 + i);
            #1;
            n_checks++;
            if (bus.DOut !== 32'd0) begin
                n_fail++;
                $display("FAIL midh_cleared r%0d: got %h want 00000000", bus.A1, bus.DOut);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] regs [5];
        regs[0] = 5'd12; regs[1] = 5'd13; regs[2] = 5'd14; regs[3] = 5'd15; regs[4] = 5'd0;
        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            bus.A1      = ($urandom_range(0, 4) == 0) ? 5'($urandom) : regs[$urandom_range(0, 3)];
            bus.A2      = regs[$urandom_range(0, 4)];
            bus.DIn     = $urandom;
            bus.WE      = ($urandom_range(0, 2) == 0);
            bus.PC      = ($urandom_range(0, 9) == 0) ? 32'd0 : $urandom;
            bus.BD      = 1'($urandom);
            bus.ExcCode = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
            bus.HWInt   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            bus.EXLClr  = ($urandom_range(0, 4) == 0);
            #1;
            n_checks++;
            if (bus.IntReq !== m_req()) begin
                n_fail++;
                $display("FAIL rnd_intreq @%0d: got %0b want %0b", i, bus.IntReq, m_req());
            end
            n_checks++;
            if (bus.DOut !== m_read(bus.A1) || bus.EPC !== m_epc) begin
                n_fail++;
                $display("FAIL rnd_read @%0d r%0d: dout %h want %h, epc %h want %h",
                         i, bus.A1, bus.DOut, m_read(bus.A1), bus.EPC, m_epc);
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_sr     = 32'd0;
        m_cause  = 32'd0;
        m_epc    = 32'd0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_mtc0();
        test_interrupt();
        test_delay_slot_exc();
        test_masking_priority();
        test_reset_mid_handler();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
